mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `mux4` datapath among four requesters. It samples a 4-bit request vector and registers a one-hot grant plus the matching 2-bit select that drives the `mux4` `s` input. A granted requester keeps ownership until it drops its request or a hold limit expires. It sits directly in front of `mux4` and is the only block allowed to drive its select.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_pick4.sv | 26 ++
 rtl/mux4_rr_arbiter.sv | 92 +++++++++
 tb/tb_mux4_rr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod 4.
import arb_pkg::*;

module rr_pick4 (
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       idx,
  output logic             any
);

  logic [1:0] cand;

  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + 2'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the mux4 select: registered one-hot grant, hold limit, back-to-back handoff.
import arb_pkg::*;

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       sel,
  output logic             busy
);

  localparam int HW          = (MAX_HOLD == 0) ? 1 : (($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1));
  localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [HW-1:0] HOLD_LAST = HOLD_LAST_I[HW-1:0];
  localparam bit   HOLD_LIMITED = (MAX_HOLD != 0);

  arb_state_t    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  logic [1:0] pick_ptr;
  logic [1:0] pick_idx;
  logic       pick_any;
  logic       expired;
  logic       release_own;

  // One picker serves both idle arbitration and release re-arbitration; on release
  // the search starts just past the current owner so it ranks lowest.
  rr_pick4 u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    pick_ptr    = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;
    expired     = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);
    release_own = !req[owner_q] || expired;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = GRANT;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_own) begin
          ptr_d = owner_q + 2'd1;
          if (pick_any) begin
            owner_d    = pick_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != {HW{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign grant = (state_q == GRANT) ? (4'b0001 << owner_q) : 4'b0000;
  assign sel   = owner_q;
  assign busy  = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: hold limits 4, 3 and unlimited on three instances.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] grant_a, grant_b, grant_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic       busy_a, busy_b, busy_c;

  int checks   = 0;
  int failures = 0;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .grant(grant_a), .sel(sel_a), .busy(busy_a)
  );
  mux4_rr_arbiter #(.MAX_HOLD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .grant(grant_b), .sel(sel_b), .busy(busy_b)
  );
  mux4_rr_arbiter #(.MAX_HOLD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .grant(grant_c), .sel(sel_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    req_a = ra;
    req_b = rb;
    req_c = rc;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [3:0] obs_grant, input logic [1:0] obs_sel, input logic obs_busy,
                             input logic [3:0] exp_grant, input logic [1:0] exp_sel, input logic exp_busy);
    checks++;
    assert ({obs_grant, obs_sel, obs_busy} === {exp_grant, exp_sel, exp_busy})
    else begin
      failures++;
      $error("[TB] FAIL %s: grant/sel/busy observed %b/%0d/%b expected %b/%0d/%b",
             tag, obs_grant, obs_sel, obs_busy, exp_grant, exp_sel, exp_busy);
    end
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_own;
    logic [1:0] exp_hold;
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    #3;
    checkOutput("reset_a", grant_a, sel_a, busy_a, 4'b0000, 2'd0, 1'b0);
    checkOutput("reset_b", grant_b, sel_b, busy_b, 4'b0000, 2'd0, 1'b0);

    applyStimulus(4'b1111, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("reset_held_req", grant_a, sel_a, busy_a, 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;

    // MAX_HOLD=4 rotation under full request: four cycles per owner, busy never drops
    for (int k = 0; k < 17; k++) begin
      stepEdge();
      exp_own = 2'((k / 4) % 4);
      checkOutput($sformatf("rotate_%0d", k), grant_a, sel_a, busy_a,
                  4'b0001 << exp_own, exp_own, 1'b1);
    end

    // Asynchronous reset pulse between edges clears outputs with no clock
    rst_n = 1'b0;
    #2;
    checkOutput("async_reset_a", grant_a, sel_a, busy_a, 4'b0000, 2'd0, 1'b0);
    #1;
    rst_n = 1'b1;
    stepEdge();
    checkOutput("first_grant_after_reset", grant_a, sel_a, busy_a, 4'b0001, 2'd0, 1'b1);

    applyStimulus(4'b0100, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("single_req2", grant_a, sel_a, busy_a, 4'b0100, 2'd2, 1'b1);

    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("idle_keeps_sel", grant_a, sel_a, busy_a, 4'b0000, 2'd2, 1'b0);

    // ptr is now 3, so search order is 3,0,1,2
    applyStimulus(4'b0101, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("ptr_fairness", grant_a, sel_a, busy_a, 4'b0001, 2'd0, 1'b1);

    applyStimulus(4'b1010, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("handoff_0_to_1", grant_a, sel_a, busy_a, 4'b0010, 2'd1, 1'b1);
    stepEdge();
    checkOutput("hold_owner1", grant_a, sel_a, busy_a, 4'b0010, 2'd1, 1'b1);

    applyStimulus(4'b1000, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("handoff_1_to_3", grant_a, sel_a, busy_a, 4'b1000, 2'd3, 1'b1);

    applyStimulus(4'b0000, 4'b0000, 4'b0000);
    stepEdge();
    checkOutput("idle_after_3", grant_a, sel_a, busy_a, 4'b0000, 2'd3, 1'b0);

    // MAX_HOLD=3 sole requester: continuous grant, counter cycles 0,1,2
    applyStimulus(4'b0000, 4'b0010, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      stepEdge();
      checkOutput($sformatf("sole_req_%0d", k), grant_b, sel_b, busy_b, 4'b0010, 2'd1, 1'b1);
      exp_hold = 2'(k % 3);
      checks++;
      assert (dut_b.hold_cnt_q === exp_hold)
      else begin
        failures++;
        $error("[TB] FAIL sole_hold_%0d: hold_cnt observed %0d expected %0d", k, dut_b.hold_cnt_q, exp_hold);
      end
    end

    // MAX_HOLD=0: owner keeps the mux indefinitely despite competitors
    applyStimulus(4'b0000, 4'b0000, 4'b0001);
    stepEdge();
    checkOutput("unlim_first", grant_c, sel_c, busy_c, 4'b0001, 2'd0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 4'b1111);
    for (int k = 0; k < 110; k++) begin
      stepEdge();
      checkOutput($sformatf("unlim_hold_%0d", k), grant_c, sel_c, busy_c, 4'b0001, 2'd0, 1'b1);
    end

    applyStimulus(4'b0000, 4'b0000, 4'b1110);
    stepEdge();
    checkOutput("unlim_release", grant_c, sel_c, busy_c, 4'b0010, 2'd1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
